// File: rtl/i2c_slave.sv
// i2c_slave: I2C target with one fixed 7-bit address.
// Oversamples SCL/SDA on i_clk, detects START/STOP, ACKs its own address,
// delivers write bytes on o_rx_data/o_rx_valid and fetches read bytes from
// i_tx_data with an o_tx_req pulse. SDA is open-drain (drives 0 or 'z only).
// Optional glitch filter on the synchronized lines: define I2C_SLAVE_FILTER_EN.
//
// state       | meaning
// S_IDLE      | SDA released, waiting for START
// S_ADDR      | shifting 7 address bits + rw on SCL rises
// S_ADDR_ACK  | ACK slot for our address (drive low fall-to-fall)
// S_WRITE     | shifting a write byte from the master
// S_WRITE_ACK | ACK slot for a write byte
// S_READ      | driving a read byte MSB first, changing on SCL falls
// S_READ_ACK  | sampling the master's ACK/NACK
// S_WAIT_STOP | not addressed / NACKed, ignore bus until START or STOP
`timescale 1ns/1ps

module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         FILTER_LEN = 3
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_i2c_scl,
  inout  wire        io_i2c_sda,
  input  logic [7:0] i_tx_data,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_tx_req,
  output logic       o_busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK, S_WAIT_STOP
  } state_t;

  if (FILTER_LEN < 1) begin : g_filter_len_chk
    $error("FILTER_LEN must be at least 1");
  end

  logic r_scl_meta, r_scl_sync, r_sda_meta, r_sda_sync;
  logic w_scl, w_sda;
  logic r_scl_d, r_sda_d;

  // Two-flop synchronizers; idle bus level is high.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_scl_meta <= 1'b1;
      r_scl_sync <= 1'b1;
      r_sda_meta <= 1'b1;
      r_sda_sync <= 1'b1;
    end else begin
      r_scl_meta <= i_i2c_scl;
      r_scl_sync <= r_scl_meta;
      r_sda_meta <= io_i2c_sda;
      r_sda_sync <= r_sda_meta;
    end
  end

`ifdef I2C_SLAVE_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [CW-1:0] r_scl_cnt, r_sda_cnt;
  logic          r_scl_flt, r_sda_flt;

  // Accept a new line level only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_scl_cnt <= '0;
      r_sda_cnt <= '0;
      r_scl_flt <= 1'b1;
      r_sda_flt <= 1'b1;
    end else begin
      if (r_scl_sync == r_scl_flt) begin
        r_scl_cnt <= '0;
      end else if (r_scl_cnt == CW'(FILTER_LEN - 1)) begin
        r_scl_flt <= r_scl_sync;
        r_scl_cnt <= '0;
      end else begin
        r_scl_cnt <= r_scl_cnt + 1'b1;
      end
      if (r_sda_sync == r_sda_flt) begin
        r_sda_cnt <= '0;
      end else if (r_sda_cnt == CW'(FILTER_LEN - 1)) begin
        r_sda_flt <= r_sda_sync;
        r_sda_cnt <= '0;
      end else begin
        r_sda_cnt <= r_sda_cnt + 1'b1;
      end
    end
  end

  assign w_scl = r_scl_flt;
  assign w_sda = r_sda_flt;
`else
  assign w_scl = r_scl_sync;
  assign w_sda = r_sda_sync;
`endif

  // Previous conditioned levels for edge detection.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
    end else begin
      r_scl_d <= w_scl;
      r_sda_d <= w_sda;
    end
  end

  logic w_scl_rise, w_scl_fall, w_start, w_stop;
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  // SCL must be high both before and after, so a coincident SCL edge is plain data.
  assign w_start = r_scl_d & w_scl & r_sda_d & ~w_sda;
  assign w_stop  = r_scl_d & w_scl & ~r_sda_d & w_sda;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [6:0] r_shift, w_shift_nxt;
  logic       r_rw, w_rw_nxt;
  logic       r_ack_phase, w_ack_phase_nxt;
  logic       r_sda_low, w_sda_low_nxt;
  logic [7:0] r_rx_data, w_rx_data_nxt;
  logic       r_rx_valid, w_rx_valid_nxt;
  logic       r_tx_req, w_tx_req_nxt;
  logic       r_busy, w_busy_nxt;

  // FSM state and datapath registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_rw        <= 1'b0;
      r_ack_phase <= 1'b0;
      r_sda_low   <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_tx_req    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_rw        <= w_rw_nxt;
      r_ack_phase <= w_ack_phase_nxt;
      r_sda_low   <= w_sda_low_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_tx_req    <= w_tx_req_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // Next-state and output logic; bus conditions override every state.
  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_shift_nxt     = r_shift;
    w_rw_nxt        = r_rw;
    w_ack_phase_nxt = r_ack_phase;
    w_sda_low_nxt   = r_sda_low;
    w_rx_data_nxt   = r_rx_data;
    w_rx_valid_nxt  = 1'b0;
    w_tx_req_nxt    = 1'b0;
    w_busy_nxt      = r_busy;
    if (w_stop) begin
      w_state_nxt   = S_IDLE;
      w_sda_low_nxt = 1'b0;
      w_busy_nxt    = 1'b0;
      w_bit_cnt_nxt = '0;
    end else if (w_start) begin
      w_state_nxt     = S_ADDR;
      w_sda_low_nxt   = 1'b0;
      w_bit_cnt_nxt   = '0;
      w_ack_phase_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: ;
        S_ADDR: begin
          if (w_scl_rise) begin
            w_shift_nxt   = {r_shift[5:0], w_sda};
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) begin
              w_bit_cnt_nxt = '0;
              if (r_shift == SLAVE_ADDR) begin
                w_state_nxt     = S_ADDR_ACK;
                w_busy_nxt      = 1'b1;
                w_rw_nxt        = w_sda;
                w_ack_phase_nxt = 1'b0;
              end else begin
                w_state_nxt = S_WAIT_STOP;
                w_busy_nxt  = 1'b0;
              end
            end
          end
        end
        S_ADDR_ACK, S_WRITE_ACK: begin
          if (!r_ack_phase) begin
            if (w_scl_fall) begin
              w_sda_low_nxt   = 1'b1;
              w_ack_phase_nxt = 1'b1;
            end
          end else begin
            if (w_scl_rise && r_state == S_ADDR_ACK && r_rw) w_tx_req_nxt = 1'b1;
            if (w_scl_fall) begin
              w_ack_phase_nxt = 1'b0;
              w_bit_cnt_nxt   = '0;
              if (r_state == S_ADDR_ACK && r_rw) begin
                w_shift_nxt   = i_tx_data[6:0];
                w_sda_low_nxt = ~i_tx_data[7];
                w_state_nxt   = S_READ;
              end else begin
                w_sda_low_nxt = 1'b0;
                w_state_nxt   = S_WRITE;
              end
            end
          end
        end
        S_WRITE: begin
          if (w_scl_rise) begin
            w_shift_nxt   = {r_shift[5:0], w_sda};
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) begin
              w_rx_data_nxt   = {r_shift, w_sda};
              w_rx_valid_nxt  = 1'b1;
              w_state_nxt     = S_WRITE_ACK;
              w_ack_phase_nxt = 1'b0;
              w_bit_cnt_nxt   = '0;
            end
          end
        end
        S_READ: begin
          if (w_scl_rise) begin
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_bit_cnt == 4'd8) begin
              w_sda_low_nxt   = 1'b0;
              w_state_nxt     = S_READ_ACK;
              w_ack_phase_nxt = 1'b0;
            end else begin
              w_sda_low_nxt = ~r_shift[6];
              w_shift_nxt   = {r_shift[5:0], 1'b0};
            end
          end
        end
        S_READ_ACK: begin
          if (!r_ack_phase) begin
            if (w_scl_rise) begin
              if (!w_sda) begin
                w_tx_req_nxt    = 1'b1;
                w_ack_phase_nxt = 1'b1;
              end else begin
                w_state_nxt = S_WAIT_STOP;
                w_busy_nxt  = 1'b0;
              end
            end
          end else if (w_scl_fall) begin
            w_shift_nxt     = i_tx_data[6:0];
            w_sda_low_nxt   = ~i_tx_data[7];
            w_bit_cnt_nxt   = '0;
            w_ack_phase_nxt = 1'b0;
            w_state_nxt     = S_READ;
          end
        end
        S_WAIT_STOP: w_busy_nxt = 1'b0;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign io_i2c_sda = r_sda_low ? 1'b0 : 1'bz;
  assign o_rx_data  = r_rx_data;
  assign o_rx_valid = r_rx_valid;
  assign o_tx_req   = r_tx_req;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: directed bus-master stimulus for i2c_slave with a byte scoreboard.
`timescale 1ns/1ps

module tb_i2c_slave;
  localparam int Q = 6;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_sda_low = 1'b0;
  logic [7:0] tx_data = 8'h00;
  wire  [7:0] rx_data;
  wire        rx_valid, tx_req, busy;
  wire        w_sda;

  assign w_sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (w_sda);

  always #5 clk = ~clk;

  i2c_slave dut (
    .i_clk(clk), .i_reset(rst), .i_i2c_scl(scl), .io_i2c_sda(w_sda),
    .i_tx_data(tx_data), .o_rx_data(rx_data), .o_rx_valid(rx_valid),
    .o_tx_req(tx_req), .o_busy(busy)
  );

  int checks = 0, failures = 0;
  int rx_cnt = 0, txreq_cnt = 0, dut_low_cnt = 0;
  logic [7:0] q_rx[$];
  logic [7:0] q_rd[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic q_wait();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  // Works from idle bus or from SCL low (repeated START).
  task automatic m_start();
    m_sda_low = 1'b0; q_wait();
    scl = 1'b1;       q_wait();
    m_sda_low = 1'b1; q_wait();
    scl = 1'b0;       q_wait();
  endtask

  task automatic m_stop();
    m_sda_low = 1'b1; q_wait();
    scl = 1'b1;       q_wait();
    m_sda_low = 1'b0; q_wait();
  endtask

  task automatic m_bit(input logic b, output logic seen);
    m_sda_low = ~b; q_wait();
    scl = 1'b1;     q_wait();
    @(negedge clk);
    seen = w_sda;
    q_wait();
    scl = 1'b0;     q_wait();
  endtask

  task automatic m_write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) m_bit(d[i], s);
    m_bit(1'b1, ack);
  endtask

  task automatic m_read_byte(output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      m_bit(1'b1, s);
      d = {d[6:0], s};
    end
  endtask

  // Output monitor: pops expected write bytes on every rx_valid pulse.
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt++;
      check("rx_expected_pending", 32'(q_rx.size() > 0), 1);
      if (q_rx.size() > 0) check("rx_data", rx_data, q_rx.pop_front());
    end
    if (tx_req) txreq_cnt++;
    if (rx_valid | tx_req) check("rx_tx_exclusive", rx_valid & tx_req, 0);
    if (w_sda === 1'b0 && !m_sda_low) dut_low_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack, s;
    logic [7:0] d;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_req", tx_req, 0);
    check("rst_sda", w_sda, 1);
    @(posedge clk); #1 rst = 1'b0;
    q_wait();

    // 1: addressed write of 0xA5
    m_start();
    m_write_byte(8'hA0, ack);
    check("t1_addr_ack", ack, 0);
    check("t1_busy", busy, 1);
    q_rx.push_back(8'hA5);
    m_write_byte(8'hA5, ack);
    check("t1_data_ack", ack, 0);
    m_stop(); q_wait();
    check("t1_rx_cnt", rx_cnt, 1);
    check("t1_rx_data", rx_data, 8'hA5);
    check("t1_busy_end", busy, 0);
    check("t1_q_empty", q_rx.size(), 0);

    // 2: other address, never driven
    dut_low_cnt = 0;
    m_start();
    m_write_byte(8'hA2, ack);
    check("t2_addr_nack", ack, 1);
    check("t2_busy", busy, 0);
    m_write_byte(8'hFF, ack);
    check("t2_data_nack", ack, 1);
    m_stop(); q_wait();
    check("t2_dut_low", dut_low_cnt, 0);
    check("t2_rx_cnt", rx_cnt, 1);

    // 3: read 0x3C (master ACK) then 0x81 (master NACK)
    txreq_cnt = 0;
    tx_data = 8'h3C; q_rd.push_back(8'h3C);
    m_start();
    m_write_byte(8'hA1, ack);
    check("t3_addr_ack", ack, 0);
    check("t3_txreq1", txreq_cnt, 1);
    check("t3_busy", busy, 1);
    m_read_byte(d);
    check("t3_rd0", d, q_rd.pop_front());
    tx_data = 8'h81; q_rd.push_back(8'h81);
    m_bit(1'b0, s);
    check("t3_txreq2", txreq_cnt, 2);
    m_read_byte(d);
    check("t3_rd1", d, q_rd.pop_front());
    m_bit(1'b1, s);
    check("t3_nack_bus", s, 1);
    check("t3_txreq_after_nack", txreq_cnt, 2);
    check("t3_busy_nack", busy, 0);
    dut_low_cnt = 0;
    m_stop(); q_wait();
    check("t3_released", dut_low_cnt, 0);

    // 4: write 0x12, repeated START, read
    rx_cnt = 0; txreq_cnt = 0;
    m_start();
    m_write_byte(8'hA0, ack);
    check("t4_addr_ack", ack, 0);
    q_rx.push_back(8'h12);
    m_write_byte(8'h12, ack);
    check("t4_data_ack", ack, 0);
    tx_data = 8'h77; q_rd.push_back(8'h77);
    m_start();
    m_write_byte(8'hA1, ack);
    check("t4_readdr_ack", ack, 0);
    check("t4_rx_cnt", rx_cnt, 1);
    check("t4_rx_data", rx_data, 8'h12);
    check("t4_txreq", txreq_cnt, 1);
    m_read_byte(d);
    check("t4_rd", d, q_rd.pop_front());
    m_bit(1'b1, s);
    m_stop(); q_wait();
    check("t4_busy_end", busy, 0);

    // 5a: reset while the address ACK is being driven
    m_start();
    for (int i = 7; i >= 0; i--) m_bit(d[0] ^ d[0] ^ ((8'hA0 >> i) & 1), s);
    m_sda_low = 1'b0; q_wait();
    @(negedge clk);
    check("t5_ack_driven", w_sda, 0);
    rst = 1'b1;
    @(negedge clk);
    check("t5_ack_reset_release", w_sda, 1);
    check("t5_ack_reset_busy", busy, 0);
    @(posedge clk); #1 rst = 1'b0;
    m_stop(); q_wait();

    // 5b: reset after 4 bits of a write byte
    rx_cnt = 0;
    m_start();
    m_write_byte(8'hA0, ack);
    check("t5_addr_ack", ack, 0);
    for (int i = 0; i < 4; i++) m_bit(1'b1, s);
    rst = 1'b1;
    @(negedge clk);
    check("t5_sda_released", w_sda, 1);
    check("t5_busy_reset", busy, 0);
    check("t5_rx_data_reset", rx_data, 0);
    @(posedge clk); #1 rst = 1'b0;
    m_stop(); q_wait();
    check("t5_no_rx", rx_cnt, 0);
    m_start();
    m_write_byte(8'hA0, ack);
    check("t5_next_addr_ack", ack, 0);
    q_rx.push_back(8'h5A);
    m_write_byte(8'h5A, ack);
    check("t5_next_data_ack", ack, 0);
    m_stop(); q_wait();
    check("t5_next_rx_cnt", rx_cnt, 1);
    check("t5_next_rx_data", rx_data, 8'h5A);
    check("t5_q_empty", q_rx.size(), 0);

`ifdef I2C_SLAVE_FILTER_EN
    // 6: 1-clk SDA glitch with SCL high is not a START
    @(posedge clk); #1 m_sda_low = 1'b1;
    @(posedge clk); #1 m_sda_low = 1'b0;
    q_wait(); q_wait();
    check("t6_busy", busy, 0);
    scl = 1'b0; q_wait();
    m_write_byte(8'hA0, ack);
    check("t6_no_ack", ack, 1);
    m_stop(); q_wait();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
